// File: rtl/phase_frame_sequencer.sv
// Byte-stream phase frame sequencer: collects NUM_CHANNELS phase bytes into a shadow
// buffer and commits them atomically; also issues calibration capture strobes.
module phase_frame_sequencer #(
  parameter int NUM_CHANNELS   = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] phases [NUM_CHANNELS],
  output logic       phase_calib_en,
  output logic       frame_done,
  output logic       err_timeout,
  output logic       busy
);

  localparam int IW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHANNELS - 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    CMD_LOAD  = 8'hFE;
  localparam logic [7:0]    CMD_CALIB = 8'hFD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    CALIB  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [7:0]    shadow [NUM_CHANNELS];
  logic          accept, wr_en, calib_nx, done_nx, to_nx;

  assign rx_ready = (state == IDLE) || (state == LOAD);
  assign accept   = rx_valid && rx_ready;
  assign busy     = (state != IDLE);

  // Next-state, index/timeout and strobe decode
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    tcnt_nx  = tcnt;
    wr_en    = 1'b0;
    calib_nx = 1'b0;
    done_nx  = 1'b0;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (rx_data == CMD_LOAD) begin
            state_nx = LOAD;
            idx_nx   = '0;
            tcnt_nx  = '0;
          end else if (rx_data == CMD_CALIB) begin
            state_nx = CALIB;
            calib_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        // Inside a frame every byte is data, command values included
        if (accept) begin
          wr_en   = 1'b1;
          idx_nx  = idx + IW'(1);
          tcnt_nx = '0;
          if (idx == LAST_IDX) begin
            state_nx = COMMIT;
          end else begin
            state_nx = LOAD;
          end
        end else if (tcnt == TO_LIMIT) begin
          to_nx    = 1'b1;
          tcnt_nx  = '0;
          state_nx = IDLE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      COMMIT: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      CALIB: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, counters, strobes and committed frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      tcnt           <= '0;
      phase_calib_en <= 1'b0;
      frame_done     <= 1'b0;
      err_timeout    <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) phases[i] <= 8'h00;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      tcnt           <= tcnt_nx;
      phase_calib_en <= calib_nx;
      frame_done     <= done_nx;
      err_timeout    <= to_nx;
      if (state == COMMIT) begin
        for (int i = 0; i < NUM_CHANNELS; i++) phases[i] <= shadow[i];
      end
    end
  end

  // Shadow buffer holds the frame under construction; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_en) shadow[idx] <= rx_data;
  end

endmodule

// File: tb/tb_phase_frame_sequencer.sv
// Self-checking bench: directed scenarios plus random byte streams, compared each
// cycle against a frame/queue-level reference model.
module tb_phase_frame_sequencer;
  localparam int NCH = 4;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] phases [NCH];
  logic       phase_calib_en, frame_done, err_timeout, busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_frame, m_commit, m_calib;
  int         m_idle;
  logic [7:0] m_q [$];
  logic [7:0] m_ph [NCH];
  bit         e_done, e_calib, e_to;

  phase_frame_sequencer #(.NUM_CHANNELS(NCH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .phases(phases), .phase_calib_en(phase_calib_en), .frame_done(frame_done),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {phases[0], phases[1], phases[2], phases[3]};
  endfunction

  function automatic logic [31:0] pack_model();
    return {m_ph[0], m_ph[1], m_ph[2], m_ph[3]};
  endfunction

  task automatic model_reset();
    m_frame = 0; m_commit = 0; m_calib = 0; m_idle = 0;
    m_q.delete();
    for (int i = 0; i < NCH; i++) m_ph[i] = 8'h00;
    e_done = 0; e_calib = 0; e_to = 0;
  endtask

  task automatic model_edge(input bit acc, input logic [7:0] d);
    e_done = 0; e_calib = 0; e_to = 0;
    if (m_commit) begin
      for (int i = 0; i < NCH; i++) m_ph[i] = m_q[i];
      m_q.delete();
      m_commit = 0;
      e_done = 1;
    end else if (m_calib) begin
      m_calib = 0;
    end else if (m_frame) begin
      if (acc) begin
        m_q.push_back(d);
        m_idle = 0;
        if (m_q.size() == NCH) begin
          m_frame = 0;
          m_commit = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          e_to = 1;
          m_frame = 0;
          m_q.delete();
        end
      end
    end else if (acc) begin
      if (d == 8'hFE) begin
        m_frame = 1; m_idle = 0; m_q.delete();
      end else if (d == 8'hFD) begin
        m_calib = 1; e_calib = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, !(m_commit || m_calib)});
    chk("busy", {31'd0, busy}, {31'd0, (m_frame || m_commit || m_calib)});
    chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
    chk("phase_calib_en", {31'd0, phase_calib_en}, {31'd0, e_calib});
    chk("err_timeout", {31'd0, err_timeout}, {31'd0, e_to});
    chk("phases", pack_dut(), pack_model());
    chk("strobe_mutex", {31'd0, ((32'(frame_done) + 32'(phase_calib_en) + 32'(err_timeout)) <= 32'd1)}, 32'd1);
  endtask

  // one clock: drive at negedge, update model at posedge, sample 1 time unit later
  task automatic step(input bit v, input logic [7:0] d, output bit acc);
    rx_valid = v;
    rx_data  = d;
    acc = v && !(m_commit || m_calib);
    @(posedge clk);
    model_edge(acc, d);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, a);
  endtask

  // sender holds the byte until accepted, bounded
  task automatic send(input logic [7:0] d);
    bit a;
    a = 0;
    for (int k = 0; k < 8 && !a; k++) step(1'b1, d, a);
    if (!a) chk("send_bound", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f);
    logic [31:0] t;
    t = f;
    send(8'hFE);
    for (int i = 0; i < NCH; i++) send(t[31-8*i -: 8]);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit a;
    logic [7:0] b;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // full frame with latency check against constants
    send(8'hFE);
    chk("busy_after_fe", {31'd0, busy}, 32'd1);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk("done_not_early", {31'd0, frame_done}, 32'd0);
    idle_cycles(1);
    chk("frame1_phases", pack_dut(), 32'h10203040);
    chk("frame1_done", {31'd0, frame_done}, 32'd1);
    idle_cycles(2);

    // calibration strobe with phases stable
    send(8'hFD);
    chk("calib_strobe", {31'd0, phase_calib_en}, 32'd1);
    chk("calib_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("calib_phases", pack_dut(), 32'h10203040);
    idle_cycles(2);

    // timeout aborts partial frame
    send(8'hFE); send(8'h11); send(8'h22);
    idle_cycles(TO);
    chk("timeout_strobe", {31'd0, err_timeout}, 32'd1);
    chk("timeout_phases", pack_dut(), 32'h10203040);
    idle_cycles(1);
    send_frame(32'h01020304);
    idle_cycles(2);
    chk("after_to_phases", pack_dut(), 32'h01020304);

    // one cycle short of timeout must not abort
    send(8'hFE); send(8'h77);
    idle_cycles(TO - 1);
    send(8'h78); send(8'h79); send(8'h7A);
    idle_cycles(2);
    chk("near_to_phases", pack_dut(), 32'h7778797A);

    // command values inside a frame are data
    send_frame(32'hFDFE00FF);
    idle_cycles(2);
    chk("cmd_in_frame", pack_dut(), 32'hFDFE00FF);

    // backpressure through COMMIT: 55 held, then accepted and ignored
    send(8'hFE); send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    send(8'h55);
    chk("bp_idle", {31'd0, busy}, 32'd0);
    idle_cycles(2);
    chk("bp_phases", pack_dut(), 32'hA1A2A3A4);

    // reset mid-frame
    send(8'hFE); send(8'hAA);
    do_reset();
    chk("rst_phases_zero", pack_dut(), 32'h00000000);
    send_frame(32'h01020304);
    idle_cycles(2);
    chk("post_rst_frame", pack_dut(), 32'h01020304);

    // reset during COMMIT and during CALIB emits no strobe
    send(8'hFE); send(8'h0A); send(8'h0B); send(8'h0C); send(8'h0D);
    do_reset();
    idle_cycles(2);
    send(8'hFD);
    do_reset();
    idle_cycles(2);

    // random streams
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          b = 8'hFE;
          step(1'b1, b, a);
        end
        3: begin
          b = 8'hFD;
          step(1'b1, b, a);
        end
        4: idle_cycles($urandom_range(10, 18));
        5: step(1'b0, 8'(($urandom)), a);
        default: begin
          b = 8'($urandom);
          step(1'b1, b, a);
        end
      endcase
    end
    idle_cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
